// File: rtl/int_ctrl_if.sv
// ---------------------------------------------------------------------------
// int_ctrl_if : request/enable/acknowledge bundle between int_ctrl and the cu
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface int_ctrl_if #(
    parameter int NUM_IRQ = 8,
    parameter int ID_W    = $clog2(NUM_IRQ)
);
    logic [NUM_IRQ-1:0] irq;
    logic               ld_en;
    logic [NUM_IRQ-1:0] en_in;
    logic [NUM_IRQ-1:0] en;
    logic               imask;
    logic               int_ack;
    logic               eoi;
    logic               hwint;
    logic [ID_W-1:0]    int_id;
    logic               int_active;
    logic [NUM_IRQ-1:0] pending;

    // Driven by the request sources and the cu
    modport master (
        output irq, ld_en, en_in, imask, int_ack, eoi,
        input  en, hwint, int_id, int_active, pending
    );

    // Implemented by int_ctrl
    modport slave (
        input  irq, ld_en, en_in, imask, int_ack, eoi,
        output en, hwint, int_id, int_active, pending
    );
endinterface

`default_nettype wire

// File: rtl/int_ctrl.sv
// ---------------------------------------------------------------------------
// int_ctrl : priority interrupt controller feeding hwint/int_id to the cu
// Optional macro INT_CTRL_LEVEL_EN selects level-sensitive sources.
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module int_ctrl #(
    parameter int NUM_IRQ = 8,
    parameter int ID_W    = $clog2(NUM_IRQ)
) (
    input  logic       clk,
    input  logic       rst,
    int_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SVC  = 2'd2
    } state_t;

    state_t             state;
    logic [NUM_IRQ-1:0] en_r;
    logic               hwint_r;
    logic [ID_W-1:0]    id_r;
    logic               active_r;
    logic [NUM_IRQ-1:0] pend;
    logic [NUM_IRQ-1:0] cand;

    function automatic logic [ID_W-1:0] prio(input logic [NUM_IRQ-1:0] v);
        prio = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (v[i]) prio = ID_W'(i);
        end
    endfunction

`ifdef INT_CTRL_LEVEL_EN
    // Level sources: a request exists exactly while the line is high and enabled
    assign pend = bus.irq & en_r;
`else
    logic [NUM_IRQ-1:0] irq_q;
    logic [NUM_IRQ-1:0] pend_r;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] ack_clr;

    assign rise    = bus.irq & ~irq_q;
    assign ack_clr = ((state == REQ) && bus.int_ack) ? (NUM_IRQ'(1) << id_r) : '0;

    // Clear before set so a fresh edge on the acknowledged source is not lost
    always_ff @(posedge clk) begin
        irq_q <= bus.irq;
        if (rst) begin
            pend_r <= '0;
        end else begin
            pend_r <= (pend_r & ~ack_clr) | rise;
        end
    end

    assign pend = pend_r;
`endif

    assign cand = pend & en_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            hwint_r  <= 1'b0;
            id_r     <= '0;
            active_r <= 1'b0;
            en_r     <= '0;
        end else begin
            if (bus.ld_en) en_r <= bus.en_in;
            case (state)
                IDLE: begin
                    if ((cand != '0) && !bus.imask) begin
                        id_r    <= prio(cand);
                        hwint_r <= 1'b1;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    // id stays frozen here; a withdrawn or masked request re-arbitrates from IDLE
                    if (bus.int_ack) begin
                        hwint_r  <= 1'b0;
                        active_r <= 1'b1;
                        state    <= SVC;
                    end else if (bus.imask || !cand[id_r]) begin
                        hwint_r <= 1'b0;
                        state   <= IDLE;
                    end
                end
                SVC: begin
                    if (bus.eoi) begin
                        active_r <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    hwint_r <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.en         = en_r;
    assign bus.hwint      = hwint_r;
    assign bus.int_id     = id_r;
    assign bus.int_active = active_r;
    assign bus.pending    = pend;

endmodule

`default_nettype wire

// File: tb/tb_int_ctrl.sv
// ---------------------------------------------------------------------------
// tb_int_ctrl : directed vector bench for int_ctrl (edge and level builds)
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_int_ctrl;
    localparam int NUM_IRQ = 8;
    localparam int ID_W    = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int_ctrl_if #(.NUM_IRQ(NUM_IRQ), .ID_W(ID_W)) bus ();

    int_ctrl #(.NUM_IRQ(NUM_IRQ), .ID_W(ID_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [7:0] irq;
        logic       ld_en;
        logic [7:0] en_in;
        logic       imask;
        logic       ack;
        logic       eoi;
        logic       hwint;
        logic [2:0] id;
        logic       act;
        logic [7:0] pend;
        logic [7:0] en;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic add(input logic [7:0] irq, input logic ld, input logic [7:0] ein,
                       input logic im, input logic ack, input logic eoi,
                       input logic hw, input logic [2:0] id, input logic act,
                       input logic [7:0] pnd, input logic [7:0] en);
        vec_t v;
        v.irq = irq; v.ld_en = ld; v.en_in = ein; v.imask = im; v.ack = ack; v.eoi = eoi;
        v.hwint = hw; v.id = id; v.act = act; v.pend = pnd; v.en = en;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic hw, input logic [2:0] id,
                         input logic act, input logic [7:0] pnd, input logic [7:0] en);
        n_vec++;
        if ({bus.hwint, bus.int_id, bus.int_active, bus.pending, bus.en} !== {hw, id, act, pnd, en}) begin
            n_err++;
            $display("FAIL %s: got hwint=%b id=%0d act=%b pend=%h en=%h, want hwint=%b id=%0d act=%b pend=%h en=%h",
                     name, bus.hwint, bus.int_id, bus.int_active, bus.pending, bus.en,
                     hw, id, act, pnd, en);
        end
    endtask

    task automatic drive(input logic [7:0] irq, input logic ld, input logic [7:0] ein,
                         input logic im, input logic ack, input logic eoi);
        bus.irq = irq; bus.ld_en = ld; bus.en_in = ein;
        bus.imask = im; bus.int_ack = ack; bus.eoi = eoi;
    endtask

    initial begin
`ifdef INT_CTRL_LEVEL_EN
        //   irq   ld ein    im ak eo | hw id ac pend  en
        add(8'h00, 1, 8'hFF, 0, 0, 0,  0, 0, 0, 8'h00, 8'hFF);
        add(8'h04, 0, 8'h00, 0, 0, 0,  1, 2, 0, 8'h04, 8'hFF);
        add(8'h04, 0, 8'h00, 0, 1, 0,  0, 2, 1, 8'h04, 8'hFF);
        add(8'h04, 0, 8'h00, 0, 0, 1,  0, 2, 0, 8'h04, 8'hFF);
        add(8'h04, 0, 8'h00, 0, 0, 0,  1, 2, 0, 8'h04, 8'hFF);
        add(8'h00, 0, 8'h00, 0, 0, 0,  0, 2, 0, 8'h00, 8'hFF);
        add(8'h00, 0, 8'h00, 0, 0, 0,  0, 2, 0, 8'h00, 8'hFF);
`else
        //   irq   ld ein    im ak eo | hw id ac pend  en
        add(8'h40, 1, 8'hFF, 0, 0, 0,  0, 0, 0, 8'h00, 8'hFF);  // irq6 held from reset
        add(8'h48, 0, 8'h00, 0, 0, 0,  0, 0, 0, 8'h08, 8'hFF);  // irq3 rises
        add(8'h48, 0, 8'h00, 0, 0, 0,  1, 3, 0, 8'h08, 8'hFF);
        add(8'h48, 0, 8'h00, 0, 1, 0,  0, 3, 1, 8'h00, 8'hFF);
        add(8'h48, 0, 8'h00, 0, 0, 1,  0, 3, 0, 8'h00, 8'hFF);
        add(8'h64, 0, 8'h00, 0, 0, 0,  0, 3, 0, 8'h24, 8'hFF);  // irq5+irq2 together
        add(8'h64, 0, 8'h00, 0, 0, 0,  1, 2, 0, 8'h24, 8'hFF);
        add(8'h64, 0, 8'h00, 0, 1, 0,  0, 2, 1, 8'h20, 8'hFF);
        add(8'h64, 0, 8'h00, 0, 0, 1,  0, 2, 0, 8'h20, 8'hFF);
        add(8'h64, 0, 8'h00, 0, 0, 0,  1, 5, 0, 8'h20, 8'hFF);
        add(8'h64, 0, 8'h00, 0, 1, 0,  0, 5, 1, 8'h00, 8'hFF);
        add(8'h64, 0, 8'h00, 0, 0, 1,  0, 5, 0, 8'h00, 8'hFF);
        add(8'h66, 0, 8'h00, 1, 0, 0,  0, 5, 0, 8'h02, 8'hFF);  // masked irq1
        add(8'h66, 0, 8'h00, 1, 0, 0,  0, 5, 0, 8'h02, 8'hFF);
        add(8'h66, 0, 8'h00, 0, 0, 0,  1, 1, 0, 8'h02, 8'hFF);
        add(8'h66, 1, 8'hFD, 0, 0, 0,  1, 1, 0, 8'h02, 8'hFD);  // disable irq1 in REQ
        add(8'h66, 0, 8'h00, 0, 0, 0,  0, 1, 0, 8'h02, 8'hFD);
        add(8'h66, 1, 8'hFF, 0, 0, 0,  0, 1, 0, 8'h02, 8'hFF);
        add(8'h66, 0, 8'h00, 0, 0, 0,  1, 1, 0, 8'h02, 8'hFF);
        add(8'h66, 0, 8'h00, 0, 1, 0,  0, 1, 1, 8'h00, 8'hFF);
        add(8'h66, 0, 8'h00, 0, 0, 1,  0, 1, 0, 8'h00, 8'hFF);
        add(8'h76, 0, 8'h00, 0, 0, 0,  0, 1, 0, 8'h10, 8'hFF);  // irq4
        add(8'h76, 0, 8'h00, 0, 0, 0,  1, 4, 0, 8'h10, 8'hFF);
        add(8'h77, 0, 8'h00, 0, 0, 0,  1, 4, 0, 8'h11, 8'hFF);  // irq0 while REQ: id frozen
        add(8'h77, 0, 8'h00, 0, 1, 0,  0, 4, 1, 8'h01, 8'hFF);
        add(8'h76, 0, 8'h00, 0, 0, 0,  0, 4, 1, 8'h01, 8'hFF);
        add(8'h77, 0, 8'h00, 0, 0, 0,  0, 4, 1, 8'h01, 8'hFF);  // edge in SVC, no nesting
        add(8'h77, 0, 8'h00, 0, 0, 1,  0, 4, 0, 8'h01, 8'hFF);
        add(8'h77, 0, 8'h00, 0, 0, 0,  1, 0, 0, 8'h01, 8'hFF);
        add(8'h76, 0, 8'h00, 0, 0, 0,  1, 0, 0, 8'h01, 8'hFF);
        add(8'h77, 0, 8'h00, 0, 1, 0,  0, 0, 1, 8'h01, 8'hFF);  // ack + new edge: set wins
        add(8'h77, 0, 8'h00, 0, 0, 1,  0, 0, 0, 8'h01, 8'hFF);
        add(8'h77, 0, 8'h00, 0, 0, 0,  1, 0, 0, 8'h01, 8'hFF);
        add(8'h77, 0, 8'h00, 0, 1, 0,  0, 0, 1, 8'h00, 8'hFF);
        add(8'h77, 0, 8'h00, 0, 0, 1,  0, 0, 0, 8'h00, 8'hFF);
        add(8'h77, 0, 8'h00, 0, 0, 1,  0, 0, 0, 8'h00, 8'hFF);  // stray eoi in IDLE
        add(8'h77, 0, 8'h00, 0, 1, 0,  0, 0, 0, 8'h00, 8'hFF);  // stray ack in IDLE
        add(8'hF7, 0, 8'h00, 0, 0, 0,  0, 0, 0, 8'h80, 8'hFF);  // irq7
        add(8'hF7, 0, 8'h00, 0, 0, 0,  1, 7, 0, 8'h80, 8'hFF);
`endif

        // Reset with irq6 already high
        drive(8'h40, 0, 8'h00, 0, 0, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("reset", 0, 0, 0, 8'h00, 8'h00);
        rst = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].irq, tbl[i].ld_en, tbl[i].en_in, tbl[i].imask, tbl[i].ack, tbl[i].eoi);
            @(posedge clk); #1;
            check($sformatf("vec%0d", i), tbl[i].hwint, tbl[i].id, tbl[i].act, tbl[i].pend, tbl[i].en);
        end

        // Reset mid-operation, then lines held high across release stay quiet
        drive(8'hF7, 0, 8'h00, 0, 0, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid", 0, 0, 0, 8'h00, 8'h00);
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            check($sformatf("held_after_rst%0d", k), 0, 0, 0, 8'h00, 8'h00);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

`default_nettype wire
